i2c_slave_ctrl: RTL and testbench

- Synthesizable I2C target-side controller that consumes the bus driven by the master side of the environment.
- Detects START/STOP, matches a 7-bit address and ACKs it.
- Stores written bytes into an internal register bank, returns bank bytes on reads, and drives SDA open-drain.
- Instantiated once per slave index, 0 to NO_OF_SLAVES-1 from the globals package. Serves as the DUT-side responder for the slave agent.

---
 rtl/i2c_globals_pkg.sv | 10 +
 rtl/i2c_slave_ctrl_pkg.sv | 31 +++
 rtl/i2c_slave_ctrl_bus_cond.sv | 64 ++++++
 rtl/i2c_slave_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_globals_pkg.sv
// ---------------------------------------------------------------------------
// i2c_globals_pkg
// Environment-wide I2C constants shared by every agent and responder.
//   NO_OF_SLAVES : number of target-side responders instantiated on the bus.
// ---------------------------------------------------------------------------
package i2c_globals_pkg;

    localparam int NO_OF_SLAVES = 4;

endpackage : i2c_globals_pkg

// File: rtl/i2c_slave_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// i2c_slave_ctrl_pkg
// Types and constants for the I2C target-side controller.
//   i2c_slave_state_e : protocol state machine encoding
//   BYTE_WIDTH        : bits per transferred byte
//   ACK / NACK        : SDA levels of the acknowledge slot
//   SLAVE_IDX_W       : width needed to number one responder instance
// ---------------------------------------------------------------------------
package i2c_slave_ctrl_pkg;

    import i2c_globals_pkg::*;

    localparam int   BYTE_WIDTH  = 8;
    localparam logic ACK         = 1'b0;
    localparam logic NACK        = 1'b1;
    localparam int   SLAVE_IDX_W = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_IGNORE    = 4'd9
    } i2c_slave_state_e;

endpackage : i2c_slave_ctrl_pkg

// File: rtl/i2c_slave_ctrl_bus_cond.sv
// ---------------------------------------------------------------------------
// i2c_bus_cond_detect
// Synchronizes the raw SCL/SDA pins into the pclk domain and derives the
// single-cycle bus events the protocol engine reacts to.
//   pclk, areset      : system clock, synchronous active-high reset
//   scl_i, sda_i      : raw bus levels
//   scl_s, sda_s      : synchronized levels
//   scl_rise/scl_fall : one-cycle SCL edge pulses
//   start_det         : SDA 1->0 while SCL high
//   stop_det          : SDA 0->1 while SCL high
// Events are combinational from the second synchronizer stage and its
// delayed copy, so the engine acts on the third pclk edge after a pin edge.
// ---------------------------------------------------------------------------
module i2c_bus_cond_detect (
    input  logic pclk,
    input  logic areset,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic scl_meta_r;
    logic scl_sync_r;
    logic scl_dly_r;
    logic sda_meta_r;
    logic sda_sync_r;
    logic sda_dly_r;

    // Two-flop synchronizers plus a one-cycle delayed copy for edge detection
    always_ff @(posedge pclk) begin
        if (areset) begin
            // An idle bus is high on both lines; resetting high avoids a
            // spurious edge or START right after reset.
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            scl_dly_r  <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
            sda_dly_r  <= 1'b1;
        end else begin
            scl_meta_r <= scl_i;
            scl_sync_r <= scl_meta_r;
            scl_dly_r  <= scl_sync_r;
            sda_meta_r <= sda_i;
            sda_sync_r <= sda_meta_r;
            sda_dly_r  <= sda_sync_r;
        end
    end

    assign scl_s     = scl_sync_r;
    assign sda_s     = sda_sync_r;
    assign scl_rise  = scl_sync_r & ~scl_dly_r;
    assign scl_fall  = ~scl_sync_r & scl_dly_r;
    // SCL must be high in both samples so an SDA change coinciding with an
    // SCL edge is never mistaken for a bus condition.
    assign start_det = scl_sync_r & scl_dly_r & sda_dly_r & ~sda_sync_r;
    assign stop_det  = scl_sync_r & scl_dly_r & ~sda_dly_r & sda_sync_r;

endmodule : i2c_bus_cond_detect

// File: rtl/i2c_slave_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_slave_ctrl
// I2C target responder with a byte-wide register bank and auto-incrementing
// register pointer. Writes: address, pointer byte, then data bytes stored
// from the pointer upward. Reads return bank bytes from the pointer upward
// until the master NACKs.
//   pclk, areset  : system clock (>= 8x SCL), synchronous active-high reset
//   scl_i, sda_i  : raw bus lines
//   sda_oe        : 1 pulls SDA low, 0 releases it
//   host_rd_addr  : host-side bank read index
//   host_rd_data  : bank[host_rd_addr], combinational
//   wr_pulse      : one-cycle strobe when a data byte is stored
//   wr_index      : bank index stored, valid with wr_pulse
//   busy          : high between START and STOP
//   nack_seen     : one-cycle strobe when the master NACKs a read byte
// ---------------------------------------------------------------------------
module i2c_slave_ctrl
    import i2c_slave_ctrl_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDRESS = 7'h68,
    parameter int         NO_OF_REGS    = 8,
    parameter logic [7:0] RESET_VALUE   = 8'h00
) (
    input  logic                          pclk,
    input  logic                          areset,
    input  logic                          scl_i,
    input  logic                          sda_i,
    output logic                          sda_oe,
    input  logic [$clog2(NO_OF_REGS)-1:0] host_rd_addr,
    output logic [BYTE_WIDTH-1:0]         host_rd_data,
    output logic                          wr_pulse,
    output logic [$clog2(NO_OF_REGS)-1:0] wr_index,
    output logic                          busy,
    output logic                          nack_seen
);

    localparam int               PTR_W   = $clog2(NO_OF_REGS);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // Bus conditioning outputs
    logic scl_s;
    logic sda_s;
    logic scl_rise_s;
    logic scl_fall_s;
    logic start_det_s;
    logic stop_det_s;

    // Registered state
    i2c_slave_state_e        state_r;
    logic [2:0]              bit_cnt_r;
    logic [BYTE_WIDTH-1:0]   shift_r;
    logic                    byte_done_r;
    logic                    rw_r;
    logic [PTR_W-1:0]        ptr_r;
    logic [BYTE_WIDTH-1:0]   tx_r;
    logic                    sda_oe_r;
    logic                    busy_r;
    logic                    wr_pulse_r;
    logic [PTR_W-1:0]        wr_index_r;
    logic                    nack_seen_r;
    logic [BYTE_WIDTH-1:0]   bank_r [NO_OF_REGS];

    // Next-state values
    i2c_slave_state_e        state_s;
    logic [2:0]              bit_cnt_s;
    logic [BYTE_WIDTH-1:0]   shift_s;
    logic                    byte_done_s;
    logic                    rw_s;
    logic [PTR_W-1:0]        ptr_s;
    logic [BYTE_WIDTH-1:0]   tx_s;
    logic                    sda_oe_s;
    logic                    busy_s;
    logic                    wr_pulse_s;
    logic [PTR_W-1:0]        wr_index_s;
    logic                    nack_seen_s;
    logic                    bank_we_s;

    // Derived strobes
    logic                    rx_sample_s;
    logic                    drive_slot_s;
    logic [BYTE_WIDTH-1:0]   rx_byte_s;

    i2c_bus_cond_detect u_bus_cond (
        .pclk      (pclk),
        .areset    (areset),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_s     (scl_s),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise_s),
        .scl_fall  (scl_fall_s),
        .start_det (start_det_s),
        .stop_det  (stop_det_s)
    );

    // byte_done_r blocks further sampling once 8 bits are in, until the ACK
    // slot has been entered on the following SCL fall.
    assign rx_sample_s  = scl_rise_s & ~byte_done_r;
    // SDA may only change while SCL is low
    assign drive_slot_s = scl_fall_s & ~scl_s;
    assign rx_byte_s    = {shift_r[BYTE_WIDTH-2:0], sda_s};

    // Next-state and output decode; bus conditions override bit activity
    always_comb begin
        state_s     = state_r;
        bit_cnt_s   = bit_cnt_r;
        shift_s     = shift_r;
        byte_done_s = byte_done_r;
        rw_s        = rw_r;
        ptr_s       = ptr_r;
        tx_s        = tx_r;
        sda_oe_s    = sda_oe_r;
        busy_s      = busy_r;
        wr_pulse_s  = 1'b0;
        wr_index_s  = wr_index_r;
        nack_seen_s = 1'b0;
        bank_we_s   = 1'b0;

        if (start_det_s) begin
            // Also covers repeated START; the pointer is deliberately kept
            state_s     = ST_ADDR;
            bit_cnt_s   = 3'd7;
            byte_done_s = 1'b0;
            sda_oe_s    = 1'b0;
            busy_s      = 1'b1;
        end else if (stop_det_s) begin
            state_s     = ST_IDLE;
            byte_done_s = 1'b0;
            sda_oe_s    = 1'b0;
            busy_s      = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_IGNORE: begin
                    sda_oe_s = 1'b0;
                end

                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (rx_sample_s) begin
                        shift_s = rx_byte_s;
                        if (bit_cnt_r == 3'd0) begin
                            byte_done_s = 1'b1;
                            if (state_r == ST_WDATA) begin
                                bank_we_s  = 1'b1;
                                wr_pulse_s = 1'b1;
                                wr_index_s = ptr_r;
                                ptr_s      = ptr_r + PTR_ONE;
                            end else begin
                                bank_we_s = 1'b0;
                            end
                        end else begin
                            bit_cnt_s = bit_cnt_r - 3'd1;
                        end
                    end else if (drive_slot_s && byte_done_r) begin
                        byte_done_s = 1'b0;
                        case (state_r)
                            ST_ADDR: begin
                                if (shift_r[BYTE_WIDTH-1:1] == SLAVE_ADDRESS) begin
                                    rw_s     = shift_r[0];
                                    sda_oe_s = 1'b1;
                                    state_s  = ST_ADDR_ACK;
                                end else begin
                                    state_s  = ST_IGNORE;
                                end
                            end
                            ST_PTR: begin
                                // Power-of-two depth: truncation is the modulo
                                ptr_s    = shift_r[PTR_W-1:0];
                                sda_oe_s = 1'b1;
                                state_s  = ST_PTR_ACK;
                            end
                            ST_WDATA: begin
                                sda_oe_s = 1'b1;
                                state_s  = ST_WDATA_ACK;
                            end
                            default: begin
                                sda_oe_s = 1'b0;
                                state_s  = ST_IDLE;
                            end
                        endcase
                    end else begin
                        sda_oe_s = sda_oe_r;
                    end
                end

                ST_ADDR_ACK: begin
                    if (drive_slot_s) begin
                        bit_cnt_s   = 3'd7;
                        byte_done_s = 1'b0;
                        if (rw_r == 1'b0) begin
                            sda_oe_s = 1'b0;
                            state_s  = ST_PTR;
                        end else begin
                            tx_s     = bank_r[ptr_r];
                            sda_oe_s = ~bank_r[ptr_r][BYTE_WIDTH-1];
                            state_s  = ST_RDATA;
                        end
                    end else begin
                        sda_oe_s = sda_oe_r;
                    end
                end

                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (drive_slot_s) begin
                        sda_oe_s    = 1'b0;
                        bit_cnt_s   = 3'd7;
                        byte_done_s = 1'b0;
                        state_s     = ST_WDATA;
                    end else begin
                        sda_oe_s = sda_oe_r;
                    end
                end

                ST_RDATA: begin
                    // bit_cnt_r is the index of the bit currently on the bus
                    if (drive_slot_s) begin
                        if (bit_cnt_r != 3'd0) begin
                            bit_cnt_s = bit_cnt_r - 3'd1;
                            sda_oe_s  = ~tx_r[bit_cnt_r - 3'd1];
                        end else begin
                            sda_oe_s    = 1'b0;
                            byte_done_s = 1'b0;
                            state_s     = ST_RDATA_ACK;
                        end
                    end else begin
                        sda_oe_s = sda_oe_r;
                    end
                end

                ST_RDATA_ACK: begin
                    // byte_done_r marks "master ACKed, next byte pending"
                    if (scl_rise_s && !byte_done_r) begin
                        if (sda_s == ACK) begin
                            ptr_s       = ptr_r + PTR_ONE;
                            byte_done_s = 1'b1;
                        end else begin
                            nack_seen_s = 1'b1;
                            state_s     = ST_IGNORE;
                        end
                    end else if (drive_slot_s && byte_done_r) begin
                        byte_done_s = 1'b0;
                        tx_s        = bank_r[ptr_r];
                        sda_oe_s    = ~bank_r[ptr_r][BYTE_WIDTH-1];
                        bit_cnt_s   = 3'd7;
                        state_s     = ST_RDATA;
                    end else begin
                        sda_oe_s = sda_oe_r;
                    end
                end

                default: begin
                    sda_oe_s = 1'b0;
                    state_s  = ST_IDLE;
                end
            endcase
        end
    end

    // Protocol state and output registers
    always_ff @(posedge pclk) begin
        if (areset) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 3'd7;
            shift_r     <= '0;
            byte_done_r <= 1'b0;
            rw_r        <= 1'b0;
            ptr_r       <= '0;
            tx_r        <= '0;
            sda_oe_r    <= 1'b0;
            busy_r      <= 1'b0;
            wr_pulse_r  <= 1'b0;
            wr_index_r  <= '0;
            nack_seen_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            bit_cnt_r   <= bit_cnt_s;
            shift_r     <= shift_s;
            byte_done_r <= byte_done_s;
            rw_r        <= rw_s;
            ptr_r       <= ptr_s;
            tx_r        <= tx_s;
            sda_oe_r    <= sda_oe_s;
            busy_r      <= busy_s;
            wr_pulse_r  <= wr_pulse_s;
            wr_index_r  <= wr_index_s;
            nack_seen_r <= nack_seen_s;
        end
    end

    // Register bank storage
    always_ff @(posedge pclk) begin
        if (areset) begin
            for (int i = 0; i < NO_OF_REGS; i++) begin
                bank_r[i] <= RESET_VALUE;
            end
        end else if (bank_we_s) begin
            bank_r[ptr_r] <= rx_byte_s;
        end
    end

    assign sda_oe       = sda_oe_r;
    assign busy         = busy_r;
    assign wr_pulse     = wr_pulse_r;
    assign wr_index     = wr_index_r;
    assign nack_seen    = nack_seen_r;
    assign host_rd_data = bank_r[host_rd_addr];

endmodule : i2c_slave_ctrl

// File: tb/tb_i2c_slave_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_ctrl
// Bit-banging I2C master against i2c_slave_ctrl (address 0x68, 8 registers).
// The expected bank contents, write indices and read bytes come from a plain
// array model updated with modulo pointer arithmetic.
// ---------------------------------------------------------------------------
module tb_i2c_slave_ctrl;

    localparam int N_REGS = 8;
    localparam int Q      = 5;   // pclk cycles per quarter SCL period

    logic       pclk = 1'b0;
    logic       areset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic [2:0] host_rd_addr = 3'd0;
    logic       sda_oe;
    logic [7:0] host_rd_data;
    logic       wr_pulse;
    logic [2:0] wr_index;
    logic       busy;
    logic       nack_seen;

    wire sda_bus = sda_m & ~sda_oe;

    int n_cmp = 0;
    int n_err = 0;
    int wr_log[$];
    int nack_cnt = 0;
    int oe_cycles = 0;
    logic [7:0] model_bank [N_REGS];

    always #5 pclk = ~pclk;

    i2c_slave_ctrl #(
        .SLAVE_ADDRESS (7'h68),
        .NO_OF_REGS    (8),
        .RESET_VALUE   (8'h00)
    ) dut (
        .pclk         (pclk),
        .areset       (areset),
        .scl_i        (scl),
        .sda_i        (sda_bus),
        .sda_oe       (sda_oe),
        .host_rd_addr (host_rd_addr),
        .host_rd_data (host_rd_data),
        .wr_pulse     (wr_pulse),
        .wr_index     (wr_index),
        .busy         (busy),
        .nack_seen    (nack_seen)
    );

    // Event monitor: logs write strobes, NACK strobes and SDA drive cycles
    always @(negedge pclk) begin
        if (wr_pulse === 1'b1) wr_log.push_back(int'(wr_index));
        if (nack_seen === 1'b1) nack_cnt++;
        if (sda_oe === 1'b1) oe_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic qtr();
        repeat (Q) @(negedge pclk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; qtr();
        scl   = 1'b1; qtr();
        sda_m = 1'b0; qtr();
        scl   = 1'b0; qtr();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; qtr();
        scl   = 1'b1; qtr();
        sda_m = 1'b1; qtr();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; qtr();
        scl = 1'b1; qtr(); qtr();
        scl = 1'b0; qtr();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic acked);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        sda_m = 1'b1; qtr();
        scl = 1'b1; qtr();
        acked = (sda_oe === 1'b1) && (sda_bus === 1'b0);
        qtr();
        scl = 1'b0; qtr();
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; qtr();
            scl = 1'b1; qtr();
            d[i] = sda_bus;
            qtr();
            scl = 1'b0; qtr();
        end
        send_bit(mack);
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < N_REGS; i++) begin
            host_rd_addr = 3'(i);
            #1;
            check(tag, host_rd_data, model_bank[i]);
        end
    endtask

    // Complete write transaction; updates the model and checks ACKs/strobes
    task automatic write_txn(input logic [7:0] p, input int len, input logic [7:0] dat [4]);
        logic ack;
        int base;
        int mp;
        int exp_idx[$];
        base = wr_log.size();
        mp = int'(p) % N_REGS;
        i2c_start();
        check("busy_after_start", busy, 1'b1);
        write_byte(8'hD0, ack); check("wr_addr_ack", ack, 1'b1);
        write_byte(p, ack);     check("wr_ptr_ack", ack, 1'b1);
        for (int i = 0; i < len; i++) begin
            write_byte(dat[i], ack);
            check("wr_data_ack", ack, 1'b1);
            model_bank[mp] = dat[i];
            exp_idx.push_back(mp);
            mp = (mp + 1) % N_REGS;
        end
        i2c_stop();
        qtr();
        check("busy_after_stop", busy, 1'b0);
        check("wr_pulse_count", wr_log.size() - base, len);
        for (int i = 0; i < len; i++) check("wr_index", wr_log[base + i], exp_idx[i]);
        check_bank("bank_after_write");
    endtask

    // Pointer write, repeated START, sequential read ending with NACK
    task automatic read_txn(input logic [7:0] p, input int len);
        logic ack;
        logic [7:0] d;
        int n0;
        int w0;
        n0 = nack_cnt;
        w0 = wr_log.size();
        i2c_start();
        write_byte(8'hD0, ack); check("rd_addr_w_ack", ack, 1'b1);
        write_byte(p, ack);     check("rd_ptr_ack", ack, 1'b1);
        i2c_start();
        write_byte(8'hD1, ack); check("rd_addr_r_ack", ack, 1'b1);
        for (int i = 0; i < len; i++) begin
            read_byte((i == len - 1) ? 1'b1 : 1'b0, d);
            check("rd_data", d, model_bank[(int'(p) + i) % N_REGS]);
        end
        i2c_stop();
        qtr();
        check("nack_seen_count", nack_cnt - n0, 1);
        check("rd_no_wr_pulse", wr_log.size() - w0, 0);
        check("busy_after_rd", busy, 1'b0);
    endtask

    initial begin
        logic [7:0] dat [4];
        logic ack;
        int w0;
        int oe0;

        for (int i = 0; i < N_REGS; i++) model_bank[i] = 8'h00;

        // Reset
        repeat (4) @(negedge pclk);
        areset = 1'b0;
        @(negedge pclk);
        check("reset_sda_oe", sda_oe, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_wr_pulse", wr_pulse, 1'b0);
        check_bank("reset_bank");
        qtr();

        // Write burst starting at register 2
        dat[0] = 8'hA5; dat[1] = 8'h3C;
        write_txn(8'h02, 2, dat);

        // Preload 7 and 0 (pointer wraps), then combined read across the wrap
        dat[0] = 8'h11; dat[1] = 8'h22;
        write_txn(8'h07, 2, dat);
        read_txn(8'h07, 2);

        // Address mismatch: never drives SDA, never writes
        w0 = wr_log.size();
        oe0 = oe_cycles;
        i2c_start();
        write_byte(8'hA0, ack); check("mismatch_addr_nack", ack, 1'b0);
        write_byte(8'h55, ack); check("mismatch_data_nack", ack, 1'b0);
        i2c_stop();
        qtr();
        check("mismatch_oe_cycles", oe_cycles - oe0, 0);
        check("mismatch_wr_pulse", wr_log.size() - w0, 0);
        check_bank("mismatch_bank");

        // Pointer overflow: 0x0A lands on register 2
        dat[0] = 8'(($urandom_range(254, 0)) + 1);
        write_txn(8'h0A, 1, dat);
        check("overflow_bank2", model_bank[2], dat[0]);

        // STOP after five data bits
        w0 = wr_log.size();
        i2c_start();
        write_byte(8'hD0, ack); check("stopmid_addr_ack", ack, 1'b1);
        write_byte(8'h05, ack); check("stopmid_ptr_ack", ack, 1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        i2c_stop();
        qtr();
        check("stopmid_wr_pulse", wr_log.size() - w0, 0);
        check("stopmid_busy", busy, 1'b0);
        check("stopmid_sda_oe", sda_oe, 1'b0);
        check_bank("stopmid_bank");

        // Reset during bit 4 of a data byte (0xF0: bits 7..4 are all 1)
        i2c_start();
        write_byte(8'hD0, ack); check("rstmid_addr_ack", ack, 1'b1);
        write_byte(8'h01, ack); check("rstmid_ptr_ack", ack, 1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        sda_m = 1'b1; qtr();
        scl = 1'b1;
        check("rstmid_busy_before", busy, 1'b1);
        @(negedge pclk);
        areset = 1'b1;
        @(negedge pclk);
        areset = 1'b0;
        check("rstmid_sda_oe", sda_oe, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        for (int i = 0; i < N_REGS; i++) model_bank[i] = 8'h00;
        check_bank("rstmid_bank");
        qtr(); qtr();

        // Full transaction after reset
        dat[0] = 8'h5A; dat[1] = 8'hC3; dat[2] = 8'h7E;
        write_txn(8'h06, 3, dat);
        read_txn(8'h06, 3);

        // Randomized write/read pairs
        for (int t = 0; t < 6; t++) begin
            logic [7:0] p;
            int len;
            p = 8'($urandom_range(255, 0));
            len = int'($urandom_range(4, 1));
            for (int i = 0; i < 4; i++) dat[i] = 8'($urandom_range(255, 0));
            write_txn(p, len, dat);
            p = 8'($urandom_range(255, 0));
            read_txn(p, int'($urandom_range(4, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_i2c_slave_ctrl
